// File: rtl/i2c_master_engine.sv
// Byte-level I2C master: START/WR/RD/STOP/RESTART commands, programmable SCL timing, clock stretching with timeout.
// Latency: one byte takes 36*QTR_PERIOD + QTR_PERIOD cycles plus any stretch; pad levels are registered.
// Backpressure: o_ready is high only in IDLE/HOLD; strobes at other times are dropped, not queued.
module i2c_master_engine #(
    parameter int QTR_PERIOD      = 250,
    parameter int CNT_W           = 16,
    parameter bit STRETCH_EN      = 1'b1,
    parameter int STRETCH_TIMEOUT = 50000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_wr_i2c,
    input  logic [2:0] i_cmd,
    input  logic [7:0] i_din,
    output logic [7:0] o_dout,
    output logic       o_ack,
    output logic       o_ready,
    output logic       o_done_tick,
    output logic       o_timeout,
    output logic [3:0] o_state,
    output logic [4:0] o_bit_count,
    inout  wire        io_sda,
    inout  wire        io_scl
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_HOLD     = 4'd1,
        ST_START1   = 4'd2,
        ST_START2   = 4'd3,
        ST_DATA1    = 4'd4,
        ST_DATA2    = 4'd5,
        ST_DATA3    = 4'd6,
        ST_DATA4    = 4'd7,
        ST_DATA_END = 4'd8,
        ST_RESTART  = 4'd9,
        ST_STOP1    = 4'd10,
        ST_STOP2    = 4'd11
    } state_e;

    localparam logic [2:0] CMD_START   = 3'b001;
    localparam logic [2:0] CMD_WR      = 3'b010;
    localparam logic [2:0] CMD_RD      = 3'b011;
    localparam logic [2:0] CMD_STOP    = 3'b100;
    localparam logic [2:0] CMD_RESTART = 3'b101;

    localparam logic [CNT_W-1:0] LIM_Q1  = CNT_W'(QTR_PERIOD - 1);
    localparam logic [CNT_W-1:0] LIM_Q2  = CNT_W'(2 * QTR_PERIOD - 1);
    localparam logic [CNT_W-1:0] LIM_STR = CNT_W'(STRETCH_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  str_q, str_d;
    logic [8:0]        tx_q, tx_d;
    logic [8:0]        rx_q, rx_d;
    logic [3:0]        bit_q, bit_d;
    logic              sda_q, sda_d;
    logic              scl_q, scl_d;
    logic [7:0]        dout_q, dout_d;
    logic              ack_q, ack_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    logic              accept;
    logic              scl_low;
    logic              last;
    logic [CNT_W-1:0]  lim;

    // Open-drain pads: only ever pull low, release to the external pull-up otherwise.
    assign io_sda = sda_q ? 1'bz : 1'b0;
    assign io_scl = scl_q ? 1'bz : 1'b0;

    // A slave holding SCL low is only meaningful while we have released it (DATA2).
    assign scl_low = STRETCH_EN && (io_scl == 1'b0);
    assign accept  = i_wr_i2c && o_ready;

    assign o_ready     = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign o_dout      = dout_q;
    assign o_ack       = ack_q;
    assign o_done_tick = done_q;
    assign o_timeout   = timeout_q;
    assign o_state     = state_q;
    assign o_bit_count = (state_q >= ST_DATA1 && state_q <= ST_DATA4) ? {1'b0, bit_q} : 5'd0;

    // State register and all datapath flops.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            str_q     <= '0;
            tx_q      <= '1;
            rx_q      <= '0;
            bit_q     <= '0;
            sda_q     <= 1'b1;
            scl_q     <= 1'b1;
            dout_q    <= '0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            str_q     <= str_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            bit_q     <= bit_d;
            sda_q     <= sda_d;
            scl_q     <= scl_d;
            dout_q    <= dout_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state, phase timing, shift registers and byte completion.
    always_comb begin
        state_d   = state_q;
        str_d     = '0;
        tx_d      = tx_q;
        rx_d      = rx_q;
        bit_d     = bit_q;
        dout_d    = dout_q;
        ack_d     = ack_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;

        case (state_q)
            ST_START1, ST_RESTART, ST_STOP1, ST_STOP2: lim = LIM_Q2;
            default:                                   lim = LIM_Q1;
        endcase
        last  = (cnt_q == lim);
        cnt_d = (state_q == ST_IDLE || state_q == ST_HOLD || last) ? '0 : cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (accept && i_cmd == CMD_START) begin
                    state_d   = ST_START1;
                    timeout_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    case (i_cmd)
                        CMD_WR: begin
                            state_d = ST_DATA1;
                            tx_d    = {i_din, 1'b1};
                            bit_d   = '0;
                        end
                        CMD_RD: begin
                            state_d = ST_DATA1;
                            tx_d    = {8'hFF, i_din[0]};
                            bit_d   = '0;
                        end
                        CMD_STOP:    state_d = ST_STOP1;
                        CMD_RESTART: state_d = ST_RESTART;
                        CMD_START: begin
                            state_d   = ST_RESTART;
                            timeout_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_START1:  if (last) state_d = ST_START2;
            ST_START2:  if (last) state_d = ST_HOLD;
            ST_DATA1:   if (last) state_d = ST_DATA2;
            ST_DATA2: begin
                if (scl_low) begin
                    // Freeze the phase while the slave stretches; abandon the byte on timeout.
                    cnt_d = cnt_q;
                    str_d = str_q + 1'b1;
                    if (str_q == LIM_STR) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        str_d     = '0;
                    end
                end else if (last) begin
                    state_d = ST_DATA3;
                    rx_d    = {rx_q[7:0], io_sda};
                end
            end
            ST_DATA3:   if (last) state_d = ST_DATA4;
            ST_DATA4: begin
                if (last) begin
                    if (bit_q == 4'd8) begin
                        state_d = ST_DATA_END;
                    end else begin
                        state_d = ST_DATA1;
                        bit_d   = bit_q + 1'b1;
                        tx_d    = {tx_q[7:0], 1'b1};
                    end
                end
            end
            ST_DATA_END: begin
                if (last) begin
                    state_d = ST_HOLD;
                    dout_d  = rx_q[8:1];
                    ack_d   = rx_q[0];
                    done_d  = 1'b1;
                end
            end
            ST_RESTART: if (last) state_d = ST_START1;
            ST_STOP1:   if (last) state_d = ST_STOP2;
            ST_STOP2:   if (last) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Pad drive levels for the state being entered, so pads change together with o_state.
    always_comb begin
        sda_d = sda_q;
        scl_d = 1'b1;
        case (state_d)
            ST_IDLE:     begin sda_d = 1'b1;    scl_d = 1'b1; end
            ST_HOLD:     begin                  scl_d = 1'b0; end
            ST_START1:   begin sda_d = 1'b0;    scl_d = 1'b1; end
            ST_START2:   begin sda_d = 1'b0;    scl_d = 1'b0; end
            ST_DATA1:    begin sda_d = tx_d[8]; scl_d = 1'b0; end
            ST_DATA2:    begin sda_d = tx_d[8]; scl_d = 1'b1; end
            ST_DATA3:    begin sda_d = tx_d[8]; scl_d = 1'b1; end
            ST_DATA4:    begin sda_d = tx_d[8]; scl_d = 1'b0; end
            ST_DATA_END: begin                  scl_d = 1'b0; end
            ST_RESTART:  begin sda_d = 1'b1;    scl_d = 1'b1; end
            ST_STOP1:    begin sda_d = 1'b0;    scl_d = 1'b1; end
            ST_STOP2:    begin sda_d = 1'b1;    scl_d = 1'b1; end
            default:     begin sda_d = 1'b1;    scl_d = 1'b1; end
        endcase
    end

endmodule

// File: tb/tb_i2c_master_engine.sv
// Directed bench for i2c_master_engine: two instances share stimulus, B has a short stretch timeout.
// Latency: checks sampled on the falling clock edge.
// Backpressure: a simple slave model acks writes, returns read data and stretches SCL on request.
module tb_i2c_master_engine;

    localparam int Q = 4;
    localparam logic [2:0] C_START = 3'b001, C_WR = 3'b010, C_RD = 3'b011,
                           C_STOP = 3'b100, C_RESTART = 3'b101;
    localparam int S_IDLE = 0, S_HOLD = 1, S_START1 = 2, S_START2 = 3, S_DATA1 = 4,
                   S_DATA2 = 5, S_DATA3 = 6, S_DATA_END = 8, S_RESTART = 9,
                   S_STOP1 = 10, S_STOP2 = 11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr  = 1'b0;
    logic [2:0] cmd = 3'b000;
    logic [7:0] din = 8'h00;
    logic       slv_sda_low = 1'b0;
    logic       slv_scl_low = 1'b0;

    wire sda_a, scl_a, sda_b, scl_b;
    pullup (sda_a);
    pullup (scl_a);
    pullup (sda_b);
    pullup (scl_b);
    assign sda_a = slv_sda_low ? 1'b0 : 1'bz;
    assign scl_a = slv_scl_low ? 1'b0 : 1'bz;
    assign sda_b = slv_sda_low ? 1'b0 : 1'bz;
    assign scl_b = slv_scl_low ? 1'b0 : 1'bz;

    logic [7:0] dout_a, dout_b;
    logic       ack_a, ack_b, rdy_a, rdy_b, done_a, done_b, to_a, to_b;
    logic [3:0] state_a, state_b;
    logic [4:0] bc_a, bc_b;

    int checks   = 0;
    int failures = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    always #5 clk = ~clk;

    i2c_master_engine #(.QTR_PERIOD(Q), .CNT_W(16), .STRETCH_EN(1'b1), .STRETCH_TIMEOUT(50000)) u_dut_a (
        .i_clk(clk), .i_reset(rst), .i_wr_i2c(wr), .i_cmd(cmd), .i_din(din),
        .o_dout(dout_a), .o_ack(ack_a), .o_ready(rdy_a), .o_done_tick(done_a),
        .o_timeout(to_a), .o_state(state_a), .o_bit_count(bc_a),
        .io_sda(sda_a), .io_scl(scl_a)
    );

    i2c_master_engine #(.QTR_PERIOD(Q), .CNT_W(16), .STRETCH_EN(1'b1), .STRETCH_TIMEOUT(16)) u_dut_b (
        .i_clk(clk), .i_reset(rst), .i_wr_i2c(wr), .i_cmd(cmd), .i_din(din),
        .o_dout(dout_b), .o_ack(ack_b), .o_ready(rdy_b), .o_done_tick(done_b),
        .o_timeout(to_b), .o_state(state_b), .o_bit_count(bc_b),
        .io_sda(sda_b), .io_scl(scl_b)
    );

    // Count done pulses; the pre-edge value is seen here, so each pulse counts once.
    always @(posedge clk) begin
        if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
        if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr  = 1'b0;
        slv_sda_low = 1'b0;
        slv_scl_low = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one command strobe for one cycle; returns on the following falling edge.
    task automatic issue(input logic [2:0] c, input logic [7:0] d);
        wr = 1'b1; cmd = c; din = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    // Number of falling edges spent in state st starting now.
    task automatic dur(input int st, output int n);
        n = 0;
        while (int'(state_a) == st && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_state(input string tag, input int st);
        int n = 0;
        while (int'(state_a) != st && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check(tag, {28'd0, state_a}, st);
    endtask

    // Run one WR/RD byte with the slave model; captures bus bits sampled in DATA2.
    task automatic do_byte(input logic [2:0] c, input logic [7:0] d, input logic [7:0] sb,
                           input bit stretch, output logic [8:0] bits, output int pulses,
                           output int bcerr, output int last_bc, output int d2len);
        int   n = 0;
        int   k = 0;
        int   idx;
        logic prev_scl;
        bits = '0; pulses = 0; bcerr = 0; last_bc = 0; d2len = 0;
        issue(c, d);
        prev_scl = scl_a;
        while (n < 3000 && done_a !== 1'b1) begin
            if (scl_a === 1'b1 && prev_scl === 1'b0) pulses++;
            prev_scl = scl_a;
            if (int'(state_a) == S_DATA1) begin
                if (int'(bc_a) != last_bc && int'(bc_a) != last_bc + 1) bcerr++;
                last_bc = int'(bc_a);
                idx = 7 - last_bc;
                if (c == C_RD) slv_sda_low = (last_bc < 8) ? !sb[idx[2:0]] : 1'b0;
                else           slv_sda_low = (last_bc == 8);
                if (stretch && last_bc == 3) slv_scl_low = 1'b1;
            end
            if (int'(state_a) == S_DATA_END) slv_sda_low = 1'b0;
            if (int'(state_a) == S_DATA2) begin
                bits[8 - int'(bc_a)] = sda_a;
                if (int'(bc_a) == 3) begin
                    d2len++;
                    if (slv_scl_low) begin
                        k++;
                        if (k == 21) slv_scl_low = 1'b0;
                    end
                end
            end
            @(negedge clk);
            n++;
        end
        slv_sda_low = 1'b0;
        slv_scl_low = 1'b0;
        check("byte_done_seen", {31'd0, done_a}, 1);
    endtask

    initial begin
        logic [8:0] bits;
        int pulses, bcerr, last_bc, d2len, n, dc_a, dc_b;

        // 1: reset values and START timing
        do_reset();
        check("rst_state", {28'd0, state_a}, S_IDLE);
        check("rst_ready", {31'd0, rdy_a}, 1);
        check("rst_dout", {24'd0, dout_a}, 0);
        check("rst_ack", {31'd0, ack_a}, 0);
        check("rst_timeout", {31'd0, to_a}, 0);
        check("rst_bitcnt", {27'd0, bc_a}, 0);
        check("rst_done", {31'd0, done_a}, 0);
        check("rst_lines", {30'd0, sda_a, scl_a}, 2'b11);
        issue(C_START, 8'h00);
        check("start1_state", {28'd0, state_a}, S_START1);
        check("start1_lines", {30'd0, sda_a, scl_a}, 2'b01);
        check("start1_ready", {31'd0, rdy_a}, 0);
        dur(S_START1, n);
        check("start1_len", n, 2 * Q);
        check("start2_state", {28'd0, state_a}, S_START2);
        check("start2_lines", {30'd0, sda_a, scl_a}, 2'b00);
        dur(S_START2, n);
        check("start2_len", n, Q);
        check("hold_state", {28'd0, state_a}, S_HOLD);
        check("hold_ready", {31'd0, rdy_a}, 1);
        check("hold_scl", {31'd0, scl_a}, 0);

        // 2: WR 0xA5 with slave ACK
        do_byte(C_WR, 8'hA5, 8'h00, 1'b0, bits, pulses, bcerr, last_bc, d2len);
        check("wr_bits", {23'd0, bits}, 9'h14A);
        check("wr_pulses", pulses, 9);
        check("wr_dout", {24'd0, dout_a}, 8'hA5);
        check("wr_ack", {31'd0, ack_a}, 0);
        check("wr_ready", {31'd0, rdy_a}, 1);

        // 3: back-to-back RD with master NACK, slave returns 0x3C
        do_byte(C_RD, 8'h01, 8'h3C, 1'b0, bits, pulses, bcerr, last_bc, d2len);
        check("rd_bits", {23'd0, bits}, 9'h079);
        check("rd_pulses", pulses, 9);
        check("rd_dout", {24'd0, dout_a}, 8'h3C);
        check("rd_ack", {31'd0, ack_a}, 1);
        check("rd_bc_steps", bcerr, 0);
        check("rd_bc_last", last_bc, 8);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done_a}, 0);
        check("done_count_2", done_cnt_a, 2);

        // 4: 20-cycle stretch in DATA2 of bit 3; B times out after 16
        dc_b = done_cnt_b;
        do_byte(C_WR, 8'h96, 8'h00, 1'b1, bits, pulses, bcerr, last_bc, d2len);
        check("str_d2len", d2len, Q + 20);
        check("str_bits", {23'd0, bits}, 9'h12C);
        check("str_pulses", pulses, 9);
        check("str_dout", {24'd0, dout_a}, 8'h96);
        check("str_ack", {31'd0, ack_a}, 0);
        check("str_a_timeout", {31'd0, to_a}, 0);
        check("to_b_flag", {31'd0, to_b}, 1);
        check("to_b_state", {28'd0, state_b}, S_IDLE);
        check("to_b_lines", {30'd0, sda_b, scl_b}, 2'b11);
        @(negedge clk);
        check("to_b_no_done", done_cnt_b, dc_b);
        issue(C_START, 8'h00);
        check("to_b_cleared", {31'd0, to_b}, 0);
        check("to_b_restarted", {28'd0, state_b}, S_START1);
        check("a_start_in_hold", {28'd0, state_a}, S_RESTART);

        // 5: ignored commands, dropped strobe, repeated start and stop
        do_reset();
        issue(C_WR, 8'h12);
        check("idle_ign_wr", {28'd0, state_a}, S_IDLE);
        issue(C_STOP, 8'h00);
        check("idle_ign_stop", {28'd0, state_a}, S_IDLE);
        issue(C_RESTART, 8'h00);
        check("idle_ign_rst", {28'd0, state_a}, S_IDLE);
        issue(C_START, 8'h00);
        issue(C_WR, 8'h55);
        wait_state("seq_hold1", S_HOLD);
        @(negedge clk);
        check("drop_not_queued", {28'd0, state_a}, S_HOLD);
        do_byte(C_WR, 8'h50, 8'h00, 1'b0, bits, pulses, bcerr, last_bc, d2len);
        check("seq_wr_bits", {23'd0, bits}, 9'h0A0);
        check("seq_wr_ack", {31'd0, ack_a}, 0);
        issue(C_RESTART, 8'h00);
        check("rs_state", {28'd0, state_a}, S_RESTART);
        check("rs_lines", {30'd0, sda_a, scl_a}, 2'b11);
        dur(S_RESTART, n);
        check("rs_len", n, 2 * Q);
        check("rs_start1_lines", {30'd0, sda_a, scl_a}, 2'b01);
        wait_state("seq_hold2", S_HOLD);
        do_byte(C_RD, 8'h01, 8'hC3, 1'b0, bits, pulses, bcerr, last_bc, d2len);
        check("seq_rd_dout", {24'd0, dout_a}, 8'hC3);
        check("seq_rd_ack", {31'd0, ack_a}, 1);
        issue(C_STOP, 8'h00);
        check("stop1_state", {28'd0, state_a}, S_STOP1);
        check("stop1_lines", {30'd0, sda_a, scl_a}, 2'b01);
        dur(S_STOP1, n);
        check("stop1_len", n, 2 * Q);
        check("stop2_lines", {30'd0, sda_a, scl_a}, 2'b11);
        dur(S_STOP2, n);
        check("stop2_len", n, 2 * Q);
        check("end_state", {28'd0, state_a}, S_IDLE);
        check("end_lines", {30'd0, sda_a, scl_a}, 2'b11);
        check("end_ready", {31'd0, rdy_a}, 1);

        // 6: reset in DATA3 of bit 5
        issue(C_START, 8'h00);
        wait_state("mid_hold", S_HOLD);
        @(negedge clk);
        dc_a = done_cnt_a;
        issue(C_WR, 8'hFF);
        n = 0;
        while (!(int'(state_a) == S_DATA3 && int'(bc_a) == 5) && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("mid_reached", {28'd0, state_a}, S_DATA3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_state", {28'd0, state_a}, S_IDLE);
        check("mid_rst_lines", {30'd0, sda_a, scl_a}, 2'b11);
        check("mid_rst_ready", {31'd0, rdy_a}, 1);
        check("mid_rst_bc", {27'd0, bc_a}, 0);
        check("mid_rst_dout", {24'd0, dout_a}, 0);
        repeat (40) @(negedge clk);
        check("mid_rst_no_done", done_cnt_a, dc_a);
        check("mid_rst_stays", {28'd0, state_a}, S_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/i2c_master_engine.md
Name: i2c_master_engine

Overview:
- Parametrised successor to the I2C master controller: byte-level I2C master driven by the same 3-bit command interface (START, WR, RD, STOP, RESTART).
- Adds several features:
  - programmable SCL timing;
  - slave clock stretching with timeout;
  - read data return and ACK/NACK capture;
  - master ACK/NACK control on reads;
  - a per-byte done pulse.
- Sits between a sequencer or CPU-side command FSM and the open-drain I2C pads.

Parameters:
- QTR_PERIOD, 250: i_clk cycles per quarter SCL period (minimum 2).
- CNT_W, 16: width of the phase and timeout counters.
- STRETCH_EN, 1: 1 = honour slave clock stretching; 0 = ignore SCL readback.
- STRETCH_TIMEOUT, 50000: maximum i_clk cycles the slave may hold SCL low in one stretch.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_wr_i2c  in  1  command strobe, qualified by o_ready.
- i_cmd  in  3  command: 001 START, 010 WR, 011 RD, 100 STOP, 101 RESTART.
- i_din  in  8  WR: byte to send; RD: bit0 = ACK bit master sends (0 ACK, 1 NACK).
- o_dout  out  8  last received byte (RD) or echoed bus byte (WR).
- o_ack  out  1  9th-bit level sampled on the last byte (0 = ACK).
- o_ready  out  1  high in IDLE and HOLD.
- o_done_tick  out  1  one-cycle pulse at the end of each WR/RD byte.
- o_timeout  out  1  sticky stretch-timeout flag.
- o_state  out  4  current FSM state code.
- o_bit_count  out  5  current bit index 0..8 in data states, else 0.
- io_sda  inout  1  open-drain SDA; drives 0 or Z.
- io_scl  inout  1  open-drain SCL; drives 0 or Z.

Behaviour:
Q denotes QTR_PERIOD.

FSM state codes:
- IDLE=0, HOLD=1, START1=2, START2=3, DATA1=4, DATA2=5, DATA3=6, DATA4=7, DATA_END=8, RESTART=9, STOP1=10, STOP2=11.

Reset (i_reset=1 at a clock edge):
- Next cycle: state IDLE, SDA and SCL released (Z), o_ready=1, o_dout=0, o_ack=0, o_done_tick=0, o_timeout=0, o_bit_count=0.
- This applies at any point, including mid-byte.

Command acceptance:
- A command is accepted only on a cycle with o_ready=1 and i_wr_i2c=1.
- IDLE: only START is accepted; all other codes are ignored.
- HOLD:
  - WR or RD -> DATA1;
  - STOP -> STOP1;
  - RESTART or START -> RESTART;
  - codes 000/110/111 are ignored.
- o_ready drops on the cycle after acceptance.

Line timing (registered drive levels, no combinational path to pads):
- START1: SDA=0, SCL=1, 2Q cycles.
- START2: SDA=0, SCL=0, Q cycles -> HOLD.
- HOLD: SCL=0, SDA unchanged.
- Each bit runs DATA1 -> DATA2 -> DATA3 -> DATA4, Q cycles each:
  - SCL=0 in DATA1, 1 in DATA2, 1 in DATA3, 0 in DATA4;
  - SDA = current tx bit.
- Nine bits per byte. After bit 8: DATA_END (SCL=0, Q cycles) -> HOLD.
- RESTART: SDA=1, SCL=1, 2Q cycles -> START1.
- STOP1: SDA=0, SCL=1, 2Q cycles.
- STOP2: SDA=1, SCL=1, 2Q cycles -> IDLE.

Shift registers:
- WR loads tx = {i_din, 1} (releases SDA for the slave ACK).
- RD loads tx = {8'hFF, i_din[0]}.
- MSB is driven first.
- rx shifts in io_sda on the last cycle of DATA2.

Byte completion (on the DATA_END -> HOLD cycle):
- o_dout = rx[8:1];
- o_ack = rx[0];
- o_done_tick = 1 for exactly one cycle.

Clock stretching (STRETCH_EN=1):
- In DATA2, the phase counter holds while io_scl reads 0.
- A separate stretch counter increments during the hold.
- If the stretch counter reaches STRETCH_TIMEOUT:
  - state -> IDLE and both lines are released next cycle;
  - o_timeout=1;
  - no o_done_tick is issued.
- o_timeout clears on the next accepted START.

Boundaries:
- o_bit_count counts 0..8 and is 0 outside data states.
- Back-to-back WR/RD commands issued in HOLD produce no extra idle SCL pulses.
- A command strobe while o_ready=0 is dropped, not queued.

Test Plan:
1. QTR_PERIOD=4, reset then START -> io_sda falls while io_scl=Z(1); START1 lasts 8 cycles, START2 lasts 4 cycles; o_state 0->2->3->1; o_ready=1 in HOLD.
2. In HOLD, WR i_din=0xA5, slave pulls SDA low on the 9th bit -> 9 SCL high pulses; SDA bits 1,0,1,0,0,1,0,1,Z; o_ack=0; o_dout=0xA5; one o_done_tick; o_ready re-asserts.
3. RD with i_din[0]=1, slave drives 0x3C -> o_dout=0x3C; master SDA Z on bit 9; o_ack=1; o_bit_count steps 0..8.
4. Slave holds SCL low 20 cycles in DATA2 of bit 3 (STRETCH_TIMEOUT=50000) -> DATA2 extended by 20 cycles, byte correct. Repeat with STRETCH_TIMEOUT=16 -> o_timeout=1, o_state=0, both lines Z, no done tick.
5. WR/STOP/RESTART strobes in IDLE -> ignored, o_state stays 0. START, WR 0x50, RESTART, RD (NACK), STOP -> repeated-start and stop waveforms correct; ends IDLE with both lines high.
6. Assert i_reset in DATA3 of bit 5 -> next cycle o_state=0, io_sda=io_scl=Z, o_ready=1, o_done_tick never pulses.
